// File: rtl/count_limit_monitor_if.sv
// Observation bus between a saturating counter and its limit monitor.
interface count_limit_monitor_if #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned SCNT_W = 8
) ();

    logic              in_valid;
    logic [WIDTH-1:0]  in_count;
    logic              clear;
    logic              sat_pulse;
    logic              at_limit;
    logic              err;
    logic [1:0]        err_code;
    logic [WIDTH-1:0]  err_value;
    logic [SCNT_W-1:0] sample_cnt;

    // Side that presents samples and reads status
    modport master (
        output in_valid,
        output in_count,
        output clear,
        input  sat_pulse,
        input  at_limit,
        input  err,
        input  err_code,
        input  err_value,
        input  sample_cnt
    );

    // Monitor side
    modport slave (
        input  in_valid,
        input  in_count,
        input  clear,
        output sat_pulse,
        output at_limit,
        output err,
        output err_code,
        output err_value,
        output sample_cnt
    );

endinterface

// File: rtl/count_limit_monitor.sv
// Observational checker for a counts-to-LIMIT saturating counter: flags
// overshoot, illegal steps and illegal exits from saturation, latching the
// first violation in sticky status registers.
module count_limit_monitor #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned LIMIT  = 3,
    parameter int unsigned SCNT_W = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    count_limit_monitor_if.slave  mon
);

    localparam int unsigned CODE_W = 2;
    localparam int unsigned STEP_W = WIDTH + 1;

    localparam logic [CODE_W-1:0] CODE_NONE    = CODE_W'(0);
    localparam logic [CODE_W-1:0] CODE_OVER    = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_JUMP    = CODE_W'(2);
    localparam logic [CODE_W-1:0] CODE_POSTSAT = CODE_W'(3);

    localparam logic [WIDTH-1:0]  LIMIT_V  = WIDTH'(LIMIT);
    localparam logic [SCNT_W-1:0] SCNT_MAX = {SCNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_SAT   = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e              state_q,      state_d;
    logic [WIDTH-1:0]    prev_q,       prev_d;
    logic                sat_pulse_q,  sat_pulse_d;
    logic                at_limit_q,   at_limit_d;
    logic                err_q,        err_d;
    logic [CODE_W-1:0]   err_code_q,   err_code_d;
    logic [WIDTH-1:0]    err_value_q,  err_value_d;
    logic [SCNT_W-1:0]   sample_cnt_q, sample_cnt_d;

    logic                viol;
    logic [CODE_W-1:0]   viol_code;
    logic                is_over;
    logic                is_limit;
    logic                is_zero;
    logic                is_hold;
    logic                is_step;

    // Sample classification; the +1 step is widened so prev=all-ones cannot wrap
    always_comb begin
        is_over  = (mon.in_count > LIMIT_V);
        is_limit = (mon.in_count == LIMIT_V);
        is_zero  = (mon.in_count == '0);
        is_hold  = (mon.in_count == prev_q);
        is_step  = ({1'b0, mon.in_count} == ({1'b0, prev_q} + STEP_W'(1)));
    end

    // Next-state and status update for one observed sample
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        sat_pulse_d  = 1'b0;
        err_d        = err_q;
        err_code_d   = err_code_q;
        err_value_d  = err_value_q;
        sample_cnt_d = sample_cnt_q;
        viol         = 1'b0;
        viol_code    = CODE_NONE;

        if (mon.clear) begin
            state_d      = ST_IDLE;
            prev_d       = '0;
            err_d        = 1'b0;
            err_code_d   = CODE_NONE;
            err_value_d  = '0;
            sample_cnt_d = '0;
        end else if (mon.in_valid && (state_q != ST_ERROR)) begin
            if (sample_cnt_q != SCNT_MAX) begin
                sample_cnt_d = sample_cnt_q + SCNT_W'(1);
            end

            if (is_over) begin
                viol      = 1'b1;
                viol_code = CODE_OVER;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_d = is_limit ? ST_SAT : ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (is_hold || is_step) begin
                            state_d = is_limit ? ST_SAT : ST_TRACK;
                        end else if (is_zero) begin
                            state_d = ST_TRACK;
                        end else begin
                            viol      = 1'b1;
                            viol_code = CODE_JUMP;
                        end
                    end
                    ST_SAT: begin
                        if (is_limit) begin
                            state_d = ST_SAT;
                        end else if (is_zero) begin
                            state_d = ST_TRACK;
                        end else begin
                            viol      = 1'b1;
                            viol_code = CODE_POSTSAT;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end

            if (viol) begin
                state_d     = ST_ERROR;
                err_d       = 1'b1;
                err_code_d  = viol_code;
                err_value_d = mon.in_count;
            end else begin
                prev_d = mon.in_count;
            end

            sat_pulse_d = (state_d == ST_SAT) && (state_q != ST_SAT);
        end

        at_limit_d = (state_d == ST_SAT);
    end

    // State and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            sat_pulse_q  <= 1'b0;
            at_limit_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= CODE_NONE;
            err_value_q  <= '0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            sat_pulse_q  <= sat_pulse_d;
            at_limit_q   <= at_limit_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_value_q  <= err_value_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign mon.sat_pulse  = sat_pulse_q;
    assign mon.at_limit   = at_limit_q;
    assign mon.err        = err_q;
    assign mon.err_code   = err_code_q;
    assign mon.err_value  = err_value_q;
    assign mon.sample_cnt = sample_cnt_q;

endmodule
